mc_controller: RTL

Multicycle MIPS control unit: a Moore FSM that sequences each instruction through fetch, decode, execute, memory and writeback cycles and drives every enable and mux select of the datapath. It sits directly upstream of the datapath top level. It produces the `reg_wenable`, `mem_wenable` and `alucontrol` signals that the datapath consumes, plus PC, IR and mux controls. It consumes `opcode`/`funct` from the instruction register and `zeroflag` from the ALU.

---
 rtl/mips_pkg.sv | 59 +++++
 rtl/mc_controller_aludec.sv | 33 +++
 rtl/mc_controller.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcode and
// funct values, ALU control codes and datapath mux selects.
package mips_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMRD,
      S_MEMWB,
      S_MEMWR,
      S_EXEC,
      S_ALUWB,
      S_BEQEX,
      S_ADDIEX,
      S_ADDIWB,
      S_JEX,
      S_HALT
   } state_t;

   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_RT    = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // States that complete an instruction and return to FETCH.
   function automatic logic is_terminal(input state_t s);
      return (s == S_MEMWB) || (s == S_MEMWR) || (s == S_ALUWB) ||
             (s == S_BEQEX) || (s == S_ADDIWB) || (s == S_JEX);
   endfunction

endpackage

// File: rtl/mc_controller_aludec.sv
// ALU decoder: maps the FSM's aluop request and the R-type funct field to
// the 3-bit ALU control code, flagging funct values the ALU cannot execute.
module aludec
   import mips_pkg::*;
(
   input  logic [1:0] aluop,
   input  logic [5:0] funct,
   output logic [2:0] alucontrol,
   output logic       illegal_funct
);

   // Decode aluop/funct; an unknown funct falls back to add so the datapath
   // sees a harmless operation in the cycle before the FSM halts.
   always_comb begin
      alucontrol    = ALU_ADD;
      illegal_funct = 1'b0;
      case (aluop)
         ALUOP_SUB: alucontrol = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct)
               FN_ADD:  alucontrol = ALU_ADD;
               FN_SUB:  alucontrol = ALU_SUB;
               FN_AND:  alucontrol = ALU_AND;
               FN_OR:   alucontrol = ALU_OR;
               FN_SLT:  alucontrol = ALU_SLT;
               default: illegal_funct = 1'b1;
            endcase
         end
         default: alucontrol = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore FSM driving the datapath enables and
// mux selects, plus a retired-instruction counter and a sticky halt flag.
//
// state   | meaning
// --------+-----------------------------------------------
// FETCH   | read instruction at PC, latch IR, PC <= PC+4
// DECODE  | compute branch target, dispatch on opcode
// MEMADR  | compute lw/sw effective address
// MEMRD   | read data memory at ALU out
// MEMWB   | write loaded data to rt
// MEMWR   | write rt data to memory at ALU out
// EXEC    | R-type ALU operation selected by funct
// ALUWB   | write ALU out to rd
// BEQEX   | compare rs/rt, load branch target if equal
// ADDIEX  | rs + sign-extended immediate
// ADDIWB  | write ALU out to rt
// JEX     | load jump target into PC
// HALT    | illegal opcode/funct seen, wait for reset
module mc_controller
   import mips_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  opcode,
   input  logic [5:0]  funct,
   input  logic        zeroflag,
   output logic        pc_wenable,
   output logic        ir_wenable,
   output logic        iord,
   output logic        mem_wenable,
   output logic        reg_wenable,
   output logic        regdst,
   output logic        memtoreg,
   output logic        alusrca,
   output logic [1:0]  alusrcb,
   output logic [1:0]  pcsrc,
   output logic [2:0]  alucontrol,
   output logic        halted,
   output logic [31:0] instr_count
);

   state_t      state;
   state_t      state_next;
   state_t      out_state;
   logic        halted_q;
   logic [31:0] count_q;
   logic [1:0]  aluop;
   logic        pcwrite;
   logic        branch;
   logic        ir_we;
   logic        mem_we;
   logic        reg_we;
   logic        illegal_funct;

   // While reset is held the outputs look like FETCH, so the decode below
   // works from FETCH rather than whatever state the register holds.
   assign out_state = reset ? state : S_FETCH;

   aludec u_aludec (
      .aluop         (aluop),
      .funct         (funct),
      .alucontrol    (alucontrol),
      .illegal_funct (illegal_funct)
   );

   // State register, retired-instruction counter and sticky halt flag.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= S_FETCH;
         count_q  <= 32'd0;
         halted_q <= 1'b0;
      end else begin
         state <= state_next;
         if (is_terminal(state)) begin
            count_q <= count_q + 32'd1;
         end
         if (state_next == S_HALT) begin
            halted_q <= 1'b1;
         end
      end
   end

   // Next-state logic; opcode is only consulted after FETCH has loaded the IR.
   always_comb begin
      state_next = S_FETCH;
      case (state)
         S_FETCH:  state_next = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_next = S_MEMADR;
               OP_RTYPE:     state_next = S_EXEC;
               OP_BEQ:       state_next = S_BEQEX;
               OP_ADDI:      state_next = S_ADDIEX;
               OP_J:         state_next = S_JEX;
               default:      state_next = S_HALT;
            endcase
         end
         S_MEMADR: state_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  state_next = S_MEMWB;
         S_EXEC:   state_next = illegal_funct ? S_HALT : S_ALUWB;
         S_ADDIEX: state_next = S_ADDIWB;
         S_HALT:   state_next = S_HALT;
         default:  state_next = S_FETCH;
      endcase
   end

   // Moore output decode; every control defaults to 0 / add.
   always_comb begin
      pcwrite  = 1'b0;
      branch   = 1'b0;
      ir_we    = 1'b0;
      mem_we   = 1'b0;
      reg_we   = 1'b0;
      iord     = 1'b0;
      regdst   = 1'b0;
      memtoreg = 1'b0;
      alusrca  = 1'b0;
      alusrcb  = SRCB_RT;
      pcsrc    = PCSRC_ALU;
      aluop    = ALUOP_ADD;
      case (out_state)
         S_FETCH: begin
            ir_we   = 1'b1;
            pcwrite = 1'b1;
            alusrcb = SRCB_FOUR;
         end
         S_DECODE: alusrcb = SRCB_IMMSH;
         S_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = SRCB_IMM;
         end
         S_MEMRD: iord = 1'b1;
         S_MEMWB: begin
            reg_we   = 1'b1;
            memtoreg = 1'b1;
         end
         S_MEMWR: begin
            iord   = 1'b1;
            mem_we = 1'b1;
         end
         S_EXEC: begin
            alusrca = 1'b1;
            aluop   = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            reg_we = 1'b1;
            regdst = 1'b1;
         end
         S_BEQEX: begin
            alusrca = 1'b1;
            aluop   = ALUOP_SUB;
            pcsrc   = PCSRC_ALUOUT;
            branch  = 1'b1;
         end
         S_ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = SRCB_IMM;
         end
         S_ADDIWB: reg_we = 1'b1;
         S_JEX: begin
            pcsrc   = PCSRC_JUMP;
            pcwrite = 1'b1;
         end
         default: ;
      endcase
   end

   assign pc_wenable  = reset & (pcwrite | (branch & zeroflag));
   assign ir_wenable  = reset & ir_we;
   assign mem_wenable = reset & mem_we;
   assign reg_wenable = reset & reg_we;
   assign halted      = reset & halted_q;
   assign instr_count = count_q;

endmodule
